imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Streams a program image byte-by-byte into instruction memory, replacing the
//   file-based preload. Holds the CPU in reset until the load completes cleanly.
//   Upstream is a byte source (UART/debug). Downstream are the memory write port
//   and the pc_reg reset.
//   Instruction fetch reads memory; this block is the writer at the other end.
// PARAMETERS
//   ADDR_W  9    byte-address width of instruction memory
//   DEPTH   512  memory size in bytes (2**ADDR_W)
//   DATA_W  8    width of one transferred byte
// PORTS
//   clk         in   1       system clock, rising edge
//   rst         in   1       synchronous reset, active-high
//   start       in   1       1-cycle pulse: begin a load (accepted in IDLE/DONE/ERR)
//   base_addr   in   ADDR_W  first byte address written
//   byte_count  in   ADDR_W+1 bytes to load, legal 1..DEPTH
//   in_valid    in   1       source has a byte on in_data
//   in_data     in   DATA_W  byte payload
//   in_last     in   1       marks final byte of image; qualified by in_valid
//   in_ready    out  1       loader accepts a byte this cycle
//   mem_we      out  1       memory write strobe
//   mem_addr    out  ADDR_W  memory write address
//   mem_wdata   out  DATA_W  memory write data
//   cpu_hold    out  1       drives pc_reg rst; 1 = CPU held in reset
//   busy        out  1       load in progress
//   done        out  1       last load completed without error (sticky)
//   err         out  1       last load aborted or rejected (sticky)
//   checksum    out  DATA_W  XOR of all bytes accepted in current load
// BEHAVIOUR
//   - Reset: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0,
//     cpu_hold=1, busy=0, done=0, err=0, checksum=0. Takes effect on the same edge.
//   - States: IDLE, LOAD, DONE, ERR.
//   - start in IDLE/DONE/ERR:
//       - byte_count in 1..DEPTH: latch base_addr and byte_count, clear checksum/done/err,
//         set cpu_hold=1 and busy=1, go to LOAD.
//       - otherwise: go to ERR, no writes.
//   - start while in LOAD is ignored.
//   - in_ready = (state==LOAD); combinational from state. Handshake = in_valid & in_ready.
//     Throughput is 1 byte/cycle. in_valid low inserts gaps with no write.
//   - Handshake at edge N: mem_we=1, mem_addr=cur_addr, mem_wdata=in_data registered
//     for cycle N+1 only. Also at edge N: checksum ^= in_data, cur_addr+1, remaining-1.
//   - Address wraps modulo DEPTH (DEPTH-1 -> 0). No write is ever dropped.
//   - Final byte (remaining==1) accepted:
//       - with in_last=1: go to DONE.
//       - with in_last=0: go to ERR. The byte is still written.
//   - in_last=1 on a non-final byte: the byte is written, then go to ERR.
//     Remaining bytes are not accepted.
//   - DONE: done=1, busy=0, cpu_hold=0, in_ready=0.
//   - ERR: err=1, busy=0, cpu_hold=1, in_ready=0. Leaves only on start or rst.
//   - rst during LOAD: return to reset state. Bytes already written stay in memory.
//     A pending mem_we is cleared.
//   - checksum holds its value in DONE/ERR until the next accepted start.
// TESTING
//   1. base=0, count=4, bytes 13,05,50,00 (last on 4th)
//      -> writes addr 0..3 one cycle after each handshake; checksum=0x46;
//         done=1; cpu_hold 1->0.
//   2. base=510, count=4 -> mem_addr sequence 510,511,0,1; done=1.
//   3. count=4, in_last on 2nd byte -> 2 writes; err=1; cpu_hold=1;
//      in_ready=0; 3rd byte never accepted.
//   4. start with count=0, then count=513 -> ERR next cycle each time;
//      no mem_we; busy stays 0.
//   5. count=3, in_valid pattern 1,0,0,1,0,1 -> exactly 3 mem_we pulses,
//      each one cycle after a handshake; addresses consecutive.
//   6. rst asserted after 2 of 4 bytes -> next cycle mem_we=0, cpu_hold=1,
//      busy=0, checksum=0; a fresh start with count=2 completes with done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream program loader for instruction memory: writes a counted image at
// base_addr, keeps the CPU in reset until the image arrives intact.
module imem_loader #(
   parameter int ADDR_W = 9,
   parameter int DEPTH  = 512,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   byte_count,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W+1)'(1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     rem_q, rem_d;
   logic [DATA_W-1:0]   cks_q, cks_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   maddr_q, maddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                count_ok;

   assign count_ok = (byte_count != '0) && (byte_count <= DEPTH_C);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         cks_q   <= '0;
         we_q    <= 1'b0;
         maddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         cks_q   <= cks_d;
         we_q    <= we_d;
         maddr_q <= maddr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      cks_d   = cks_q;
      we_d    = 1'b0;
      maddr_d = maddr_q;
      wdata_d = wdata_q;
      case (state_q)
         S_LOAD: begin
            // start is deliberately ignored here; only accepted bytes advance the load
            if (in_valid) begin
               we_d    = 1'b1;
               maddr_d = addr_q;
               wdata_d = in_data;
               cks_d   = cks_q ^ in_data;
               addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
               rem_d   = rem_q - ONE_C;
               if (rem_q == ONE_C) begin
                  state_d = in_last ? S_DONE : S_ERR;
               end else if (in_last) begin
                  state_d = S_ERR;
               end
            end
         end
         default: begin
            if (start) begin
               if (count_ok) begin
                  addr_d  = base_addr;
                  rem_d   = byte_count;
                  cks_d   = '0;
                  state_d = S_LOAD;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
      endcase
   end

   assign in_ready  = (state_q == S_LOAD);
   assign busy      = (state_q == S_LOAD);
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign cpu_hold  = (state_q != S_DONE);
   assign mem_we    = we_q;
   assign mem_addr  = maddr_q;
   assign mem_wdata = wdata_q;
   assign checksum  = cks_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: driver queues expected memory writes, a
// negedge monitor matches every mem_we pulse against them, including timing.
module tb_imem_loader;

   logic       clk = 1'b0;
   logic       rst, start, in_valid, in_last;
   logic [8:0] base_addr;
   logic [9:0] byte_count;
   logic [7:0] in_data;
   logic       in_ready, mem_we, cpu_hold, busy, done, err;
   logic [8:0] mem_addr;
   logic [7:0] mem_wdata, checksum;

   typedef struct {
      logic [8:0] a;
      logic [7:0] d;
      int         due;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   int  writes_seen = 0;
   int  w0;

   imem_loader #(.ADDR_W(9), .DEPTH(512), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
      .byte_count(byte_count), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
      .busy(busy), .done(done), .err(err), .checksum(checksum)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every write must match the head of the queue at its due cycle
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         writes_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got addr=%0d data=%02h at cyc %0d, required no write",
                     mem_addr, mem_wdata, cyc);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.a || mem_wdata !== e.d || cyc != e.due) begin
               errors++;
               $display("FAIL write: got addr=%0d data=%02h cyc=%0d, required addr=%0d data=%02h cyc=%0d",
                        mem_addr, mem_wdata, cyc, e.a, e.d, e.due);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         wr_t e;
         e = exp_q.pop_front();
         checks++;
         errors++;
         $display("FAIL missing_write: got no mem_we at cyc %0d, required addr=%0d data=%02h",
                  cyc, e.a, e.d);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_start(input int base, input int count);
      base_addr  = 9'(base);
      byte_count = 10'(count);
      start      = 1'b1;
      tick();
      start      = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic last, input logic accept, input int addr);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      if (accept) exp_q.push_back('{a: 9'(addr), d: d, due: cyc + 1});
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic status(input string tag, input int e_done, input int e_err,
                         input int e_busy, input int e_hold, input int e_rdy);
      chk({tag, "_done"},  int'(done),     e_done);
      chk({tag, "_err"},   int'(err),      e_err);
      chk({tag, "_busy"},  int'(busy),     e_busy);
      chk({tag, "_hold"},  int'(cpu_hold), e_hold);
      chk({tag, "_ready"}, int'(in_ready), e_rdy);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_data = '0; base_addr = '0; byte_count = '0;
      tick(); tick();

      // Reset state
      status("rst", 0, 0, 0, 1, 0);
      chk("rst_we",    int'(mem_we),    0);
      chk("rst_addr",  int'(mem_addr),  0);
      chk("rst_wdata", int'(mem_wdata), 0);
      chk("rst_cks",   int'(checksum),  0);
      rst = 1'b0;
      tick();

      // 1: base 0, four bytes, clean finish
      do_start(0, 4);
      status("t1_load", 0, 0, 1, 1, 1);
      send(8'h13, 0, 1, 0);
      send(8'h05, 0, 1, 1);
      send(8'h50, 0, 1, 2);
      send(8'h00, 1, 1, 3);
      status("t1_end", 1, 0, 0, 0, 0);
      chk("t1_cks", int'(checksum), 'h46);
      tick();

      // 4a: zero count from DONE is rejected
      do_start(0, 0);
      status("t4a", 0, 1, 0, 1, 0);
      chk("t4a_cks_held", int'(checksum), 'h46);
      tick();

      // 2: address wrap 510,511,0,1
      do_start(510, 4);
      send(8'h01, 0, 1, 510);
      send(8'h02, 0, 1, 511);
      send(8'h04, 0, 1, 0);
      send(8'h08, 1, 1, 1);
      status("t2_end", 1, 0, 0, 0, 0);
      chk("t2_cks", int'(checksum), 'h0F);
      tick();

      // 4b: count 513 exceeds depth
      do_start(0, 513);
      status("t4b", 0, 1, 0, 1, 0);
      tick();

      // 3: early in_last aborts after writing its byte; further bytes refused
      do_start(40, 4);
      send(8'hA1, 0, 1, 40);
      send(8'hB2, 1, 1, 41);
      status("t3_err", 0, 1, 0, 1, 0);
      chk("t3_cks", int'(checksum), 'h13);
      send(8'hC3, 0, 0, 0);
      chk("t3_still_err", int'(err), 1);
      tick();

      // 5: gaps in in_valid
      w0 = writes_seen;
      do_start(100, 3);
      send(8'h11, 0, 1, 100);
      tick(); tick();
      send(8'h22, 0, 1, 101);
      tick();
      send(8'h44, 1, 1, 102);
      tick();
      chk("t5_nwrites", writes_seen - w0, 3);
      status("t5_end", 1, 0, 0, 0, 0);
      chk("t5_cks", int'(checksum), 'h77);

      // 6: reset mid-load, colliding with a third handshake
      do_start(20, 4);
      send(8'h5A, 0, 1, 20);
      send(8'h3C, 0, 1, 21);
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h99;
      tick();
      rst = 1'b0; in_valid = 1'b0;
      chk("t6_we", int'(mem_we), 0);
      chk("t6_cks", int'(checksum), 0);
      status("t6_rst", 0, 0, 0, 1, 0);
      do_start(300, 2);
      send(8'hF0, 0, 1, 300);
      send(8'h0F, 1, 1, 301);
      status("t6_end", 1, 0, 0, 0, 0);
      chk("t6_cks_end", int'(checksum), 'hFF);

      tick(); tick();
      chk("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

endmodule
